// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, with a start/busy/done handshake.
// Optional `zero` result flag is built when SERIAL_SUB_ZERO_EN is defined.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Borr
`ifdef SERIAL_SUB_ZERO_EN
  ,
  output logic             zero
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_sa, r_sb, r_res;
  logic             r_bflop;
  logic [CW-1:0]    r_cnt;

  logic             w_x, w_b1, w_d, w_b2, w_bout, w_last;
  logic [WIDTH-1:0] w_res_nxt;

  // Two cascaded half-subtractors form the shared borrow cell.
  assign w_x       = r_sa[0] ^ r_sb[0];
  assign w_b1      = ~r_sa[0] & r_sb[0];
  assign w_d       = w_x ^ r_bflop;
  assign w_b2      = ~w_x & r_bflop;
  assign w_bout    = w_b1 | w_b2;
  assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};
  assign w_last    = (r_cnt == LAST);

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_bflop <= 1'b0;
      r_cnt   <= '0;
      D       <= '0;
      Borr    <= 1'b0;
`ifdef SERIAL_SUB_ZERO_EN
      zero    <= 1'b0;
`endif
    end else begin
      if (r_state == S_IDLE && start) begin
        r_sa    <= a;
        r_sb    <= b;
        r_bflop <= 1'b0;
        r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        r_sa    <= r_sa >> 1;
        r_sb    <= r_sb >> 1;
        r_res   <= w_res_nxt;
        r_bflop <= w_bout;
        r_cnt   <= r_cnt + CW'(1);
        // Visible result only changes on the final bit so D never shows partial values.
        if (w_last) begin
          D    <= w_res_nxt;
          Borr <= w_bout;
`ifdef SERIAL_SUB_ZERO_EN
          zero <= (w_res_nxt == '0);
`endif
        end
      end
    end
  end

endmodule
